// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential signed radix-2 Booth multiplier, one product per 18 cycles.
// twos_complement_adder is the shared add/sub datapath that each Booth iteration drives.
module twos_complement_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + (b ^ {WIDTH{sub}}) + WIDTH'(sub);
endmodule

module booth_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_reg, q_reg, m_reg, sum, a_nx;
    logic [CW-1:0]    count;
    logic             q_1, use_sum, sub, ovf, ext;

    twos_complement_adder #(.WIDTH(WIDTH)) u_add (
        .a   (a_reg),
        .b   (m_reg),
        .sub (sub),
        .sum (sum)
    );

    always_comb begin
        use_sum  = q_reg[0] ^ q_1;
        sub      = q_reg[0] & ~q_1;
        a_nx     = use_sum ? sum : a_reg;
        // sign of the effective operand is M's sign flipped on subtract, which also covers M = -2^(WIDTH-1)
        ovf      = use_sum & (a_reg[WIDTH-1] == (m_reg[WIDTH-1] ^ sub)) & (sum[WIDTH-1] != a_reg[WIDTH-1]);
        ext      = ovf ? ~a_nx[WIDTH-1] : a_nx[WIDTH-1];
        busy     = state != IDLE;
        done     = state == DONE;
        state_nx = (state == IDLE && start)       ? RUN  :
                   (state == RUN && count == '0)  ? DONE :
                   (state == DONE)                ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            q_reg   <= '0;
            m_reg   <= '0;
            q_1     <= 1'b0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                m_reg   <= multiplicand;
                q_reg   <= multiplier;
                a_reg   <= '0;
                q_1     <= 1'b0;
                count   <= CW'(WIDTH);
                product <= '0;
            end else if (state == RUN && count != '0) begin
                a_reg <= {ext, a_nx[WIDTH-1:1]};
                q_reg <= {a_nx[0], q_reg[WIDTH-1:1]};
                q_1   <= q_reg[0];
                count <= count - CW'(1);
            end else if (state == RUN) begin
                product <= {a_reg, q_reg};
            end
        end
    end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vectors with a queue scoreboard; the monitor pops on every done pulse.
module tb_booth_multiplier;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] multiplicand = '0, multiplier = '0;
    logic        busy, done;
    logic [31:0] product;
    logic [31:0] exp_q[$];
    int          vectors = 0, miscompares = 0, dones = 0;

    booth_multiplier #(.WIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            dones++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got product 0x%08h expected no done", product);
            end else begin
                chk("product", product, exp_q.pop_front());
            end
        end
    end

    task automatic wait_done(input string name, input int expect_n, input int first_n);
        int n;
        n = first_n;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (expect_n > 0) chk({name, "_latency"}, 32'(n), 32'(expect_n));
        else chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy"}, {31'd0, busy}, 32'd1);
        chk({name, "_cleared"}, product, 32'd0);
        wait_done(name, 18, 1);
        @(negedge clk);
        chk({name, "_hold"}, product, exp);
        chk({name, "_done_drop"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int target, n;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {busy, done, 30'd0}, 32'd0);
        chk("reset_product", product, 32'd0);
        rst = 1'b0;

        run("3x5", 16'h0003, 16'h0005, 32'h0000_000F);
        run("m3x5", 16'hFFFD, 16'h0005, 32'hFFFF_FFF1);
        run("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000);
        run("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000);
        run("zero_x", 16'h0000, 16'h1234, 32'h0000_0000);
        run("m1x7", 16'h0007, 16'hFFFF, 32'hFFFF_FFF9);

        // start pulses during RUN and during DONE must both be ignored
        @(negedge clk);
        multiplicand = 16'd7;
        multiplier   = 16'd7;
        start        = 1'b1;
        exp_q.push_back(32'h0000_0031);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("7x7", 0, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("7x7_after_done_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("7x7_done_start_ignored", {31'd0, busy}, 32'd0);
        chk("7x7_hold", product, 32'h0000_0031);

        // held start produces back-to-back products
        multiplicand = 16'hFFFF;
        multiplier   = 16'h0002;
        exp_q.push_back(32'hFFFF_FFFE);
        exp_q.push_back(32'hFFFF_FFFE);
        target = dones + 2;
        start  = 1'b1;
        n = 0;
        while (dones < target && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_retrigger_count", 32'(dones), 32'(target));
        chk("held_idle", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of RUN aborts without a done pulse
        @(negedge clk);
        multiplicand = 16'h1234;
        multiplier   = 16'h5678;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, 30'd0}, 32'd0);
        chk("abort_product", product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        run("m1xm1", 16'hFFFF, 16'hFFFF, 32'h0000_0001);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
